// File: rtl/lb_reset_sequencer.sv
// lb_reset_sequencer
//
// Sequences reset release for the PicoBlaze subsystem. After the synchronised system reset
// deasserts, the peripheral bank is released first. The core is released a fixed number of
// cycles later, so peripherals are stable before the first instruction fetch. A software
// reset strobe or a watchdog expiry re-enters the sequence, and the cause is recorded.
//
// Ports:
//   clk         system clock
//   resetb      asynchronous active-low reset
//   sys_rst_in  synchronous active-high reset from the reset processor
//   sw_rst_req  one-cycle software reset strobe (honoured only in RUN)
//   wdt_en      watchdog enable, level
//   wdt_kick    one-cycle watchdog restart strobe
//   periph_rst  active-high peripheral reset, registered
//   cpu_rst     active-high core reset, registered
//   seq_done    high while in RUN, registered
//   rst_cause   0 = button/power, 1 = software, 2 = watchdog

module lb_reset_sequencer #(
    parameter int unsigned PERIPH_HOLD = 16,
    parameter int unsigned CPU_DELAY   = 8,
    parameter int unsigned WDT_WIDTH   = 16,
    parameter int unsigned WDT_TIMEOUT = 50000
) (
    input  logic       clk,
    input  logic       resetb,
    input  logic       sys_rst_in,
    input  logic       sw_rst_req,
    input  logic       wdt_en,
    input  logic       wdt_kick,
    output logic       periph_rst,
    output logic       cpu_rst,
    output logic       seq_done,
    output logic [1:0] rst_cause
);

    localparam int unsigned MaxSeq = (PERIPH_HOLD > CPU_DELAY) ? PERIPH_HOLD : CPU_DELAY;
    localparam int unsigned CntW   = $clog2(MaxSeq) + 1;

    localparam logic [1:0] CauseBtn = 2'd0;
    localparam logic [1:0] CauseSw  = 2'd1;
    localparam logic [1:0] CauseWdt = 2'd2;

    typedef enum logic [1:0] {StHold, StWaitP, StWaitC, StRun} state_e;

    state_e                 state_q, state_d;
    logic [CntW-1:0]        cnt_q, cnt_d;
    logic [WDT_WIDTH-1:0]   wdt_q, wdt_d;
    logic [1:0]             cause_q, cause_d;
    logic                   periph_q, periph_d;
    logic                   cpu_q, cpu_d;
    logic                   done_q, done_d;
    logic                   wdt_expire;

    // Expiry needs the count to have reached TIMEOUT-1 with no kick this cycle; a kick wins.
    assign wdt_expire = (state_q == StRun) && wdt_en && !wdt_kick &&
                        (wdt_q == WDT_WIDTH'(WDT_TIMEOUT - 1));

    // State and registered outputs
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            state_q  <= StHold;
            cnt_q    <= '0;
            wdt_q    <= '0;
            cause_q  <= CauseBtn;
            periph_q <= 1'b1;
            cpu_q    <= 1'b1;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            wdt_q    <= wdt_d;
            cause_q  <= cause_d;
            periph_q <= periph_d;
            cpu_q    <= cpu_d;
            done_q   <= done_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cause_d = cause_q;

        if (sys_rst_in) begin
            state_d = StHold;
            cnt_d   = '0;
            cause_d = CauseBtn;
        end else begin
            unique case (state_q)
                StHold: begin
                    state_d = StWaitP;
                    cnt_d   = CntW'(PERIPH_HOLD - 1);
                end
                StWaitP: begin
                    if (cnt_q == '0) begin
                        state_d = StWaitC;
                        cnt_d   = CntW'(CPU_DELAY - 1);
                    end else begin
                        cnt_d = cnt_q - CntW'(1);
                    end
                end
                StWaitC: begin
                    if (cnt_q == '0) begin
                        state_d = StRun;
                    end else begin
                        cnt_d = cnt_q - CntW'(1);
                    end
                end
                StRun: begin
                    // Watchdog expiry outranks a coincident software request.
                    if (wdt_expire) begin
                        state_d = StHold;
                        cause_d = CauseWdt;
                    end else if (sw_rst_req) begin
                        state_d = StHold;
                        cause_d = CauseSw;
                    end
                end
                default: state_d = StHold;
            endcase
        end

        if ((state_q != StRun) || !wdt_en || wdt_kick) begin
            wdt_d = '0;
        end else begin
            wdt_d = wdt_q + WDT_WIDTH'(1);
        end
    end

    // Output decode from the next state so outputs switch on the same edge as the state.
    always_comb begin
        periph_d = (state_d == StHold) || (state_d == StWaitP);
        cpu_d    = (state_d != StRun);
        done_d   = (state_d == StRun);
    end

    assign periph_rst = periph_q;
    assign cpu_rst    = cpu_q;
    assign seq_done   = done_q;
    assign rst_cause  = cause_q;

endmodule

// File: tb/tb_lb_reset_sequencer.sv
module tb_lb_reset_sequencer;

    logic       clk = 1'b0;
    logic       resetb;
    logic       sys_rst_in;
    logic       sw_rst_req;
    logic       wdt_en;
    logic       wdt_kick;
    logic       periph_rst;
    logic       cpu_rst;
    logic       seq_done;
    logic [1:0] rst_cause;

    int n_checks = 0;
    int n_fail   = 0;

    // Packed observation: {periph_rst, cpu_rst, seq_done, rst_cause}
    localparam logic [4:0] HoldBtn = 5'b110_00;
    localparam logic [4:0] HoldSw  = 5'b110_01;
    localparam logic [4:0] HoldWdt = 5'b110_10;
    localparam logic [4:0] RunBtn  = 5'b001_00;
    localparam logic [4:0] RunSw   = 5'b001_01;
    localparam logic [4:0] RunWdt  = 5'b001_10;
    localparam logic [4:0] WcBtn   = 5'b010_00;
    localparam logic [4:0] WcSw    = 5'b010_01;

    lb_reset_sequencer #(
        .PERIPH_HOLD(16),
        .CPU_DELAY  (8),
        .WDT_WIDTH  (16),
        .WDT_TIMEOUT(10)
    ) dut (
        .clk       (clk),
        .resetb    (resetb),
        .sys_rst_in(sys_rst_in),
        .sw_rst_req(sw_rst_req),
        .wdt_en    (wdt_en),
        .wdt_kick  (wdt_kick),
        .periph_rst(periph_rst),
        .cpu_rst   (cpu_rst),
        .seq_done  (seq_done),
        .rst_cause (rst_cause)
    );

    always #5 clk = ~clk;

    function automatic logic [4:0] obs();
        return {periph_rst, cpu_rst, seq_done, rst_cause};
    endfunction

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_run(input string tag);
        for (int i = 0; i < 60; i++) begin
            if (seq_done) break;
            step(1);
        end
        check(tag, {7'd0, seq_done}, 8'd1);
    endtask

    initial begin
        resetb     = 1'b0;
        sys_rst_in = 1'b1;
        sw_rst_req = 1'b0;
        wdt_en     = 1'b0;
        wdt_kick   = 1'b0;

        step(2);
        check("reset_state", {3'd0, obs()}, {3'd0, HoldBtn});
        #2 resetb = 1'b1;
        step(2);
        check("hold_while_sys_rst", {3'd0, obs()}, {3'd0, HoldBtn});

        // Release: edge k is the first edge sampling sys_rst_in=0.
        sys_rst_in = 1'b0;
        step(1);
        check("rel_k", {3'd0, obs()}, {3'd0, HoldBtn});
        step(15);
        check("rel_k15", {3'd0, obs()}, {3'd0, HoldBtn});
        step(1);
        check("rel_k16_periph", {3'd0, obs()}, {3'd0, WcBtn});
        step(7);
        check("rel_k23_cpu", {3'd0, obs()}, {3'd0, WcBtn});
        step(1);
        check("rel_k24_run", {3'd0, obs()}, {3'd0, RunBtn});

        // Software reset from RUN; pulse sampled at edge p.
        sw_rst_req = 1'b1;
        step(1);
        sw_rst_req = 1'b0;
        check("sw_p", {3'd0, obs()}, {3'd0, HoldSw});
        step(16);
        check("sw_p16", {3'd0, obs()}, {3'd0, HoldSw});
        step(1);
        check("sw_p17_periph", {3'd0, obs()}, {3'd0, WcSw});
        sw_rst_req = 1'b1;
        step(1);
        sw_rst_req = 1'b0;
        check("sw_ignored_waitc", {3'd0, obs()}, {3'd0, WcSw});
        step(6);
        check("sw_p24", {3'd0, obs()}, {3'd0, WcSw});
        step(1);
        check("sw_p25_run", {3'd0, obs()}, {3'd0, RunSw});

        // Watchdog: enable sampled at e0, kicks at e0+5 and e0+14, expiry at e0+24.
        wdt_en = 1'b1;
        for (int i = 0; i <= 24; i++) begin
            wdt_kick = (i == 5) || (i == 14);
            step(1);
            check($sformatf("wdt_run_%0d", i), {3'd0, obs()},
                  {3'd0, (i < 24) ? RunSw : HoldWdt});
        end
        wdt_kick = 1'b0;
        wdt_en   = 1'b0;
        wait_run("wdt_back_to_run");
        check("wdt_cause_kept", {3'd0, obs()}, {3'd0, RunWdt});

        // Kick on the would-be expiry edge (e0+9), then sys_rst_in on the next expiry edge.
        wdt_en = 1'b1;
        for (int i = 0; i <= 19; i++) begin
            wdt_kick   = (i == 9);
            sys_rst_in = (i == 19);
            step(1);
            check($sformatf("wdt_kick_sys_%0d", i), {3'd0, obs()},
                  {3'd0, (i < 19) ? RunWdt : HoldBtn});
        end
        wdt_kick   = 1'b0;
        sys_rst_in = 1'b0;
        wdt_en     = 1'b0;
        wait_run("sys_back_to_run");

        // sys_rst_in glitch during WAIT_P restarts the whole sequence.
        sys_rst_in = 1'b1;
        step(1);
        sys_rst_in = 1'b0;
        check("glitch_hold", {3'd0, obs()}, {3'd0, HoldBtn});
        step(6);
        check("glitch_in_waitp", {3'd0, obs()}, {3'd0, HoldBtn});
        sys_rst_in = 1'b1;
        step(1);
        sys_rst_in = 1'b0;
        check("glitch_rehold", {3'd0, obs()}, {3'd0, HoldBtn});
        step(16);
        check("glitch_k15", {3'd0, obs()}, {3'd0, HoldBtn});
        step(1);
        check("glitch_k16", {3'd0, obs()}, {3'd0, WcBtn});
        step(8);
        check("glitch_k24", {3'd0, obs()}, {3'd0, RunBtn});

        // Expiry coincident with sw_rst_req: watchdog cause wins.
        wdt_en = 1'b1;
        for (int i = 0; i <= 9; i++) begin
            sw_rst_req = (i == 9);
            step(1);
            check($sformatf("wdt_vs_sw_%0d", i), {3'd0, obs()},
                  {3'd0, (i < 9) ? RunBtn : HoldWdt});
        end
        sw_rst_req = 1'b0;
        wdt_en     = 1'b0;
        wait_run("wdt_sw_back_to_run");
        check("wdt_sw_run_cause", {3'd0, obs()}, {3'd0, RunWdt});

        // Asynchronous reset mid-cycle in RUN.
        #3 resetb = 1'b0;
        #1;
        check("async_reset", {3'd0, obs()}, {3'd0, HoldBtn});
        #2 resetb = 1'b1;
        step(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
